// File: rtl/fft_fifo_pkg.sv
// Shared constants, flag bundle and helper functions for the synchronous FIFO.
// Thresholds are passed in so the flag decode lives in one place for every instance.
package fft_fifo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 16;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic fifo_flags_t calc_flags(input int count, input int depth,
                                               input int af_thresh, input int ae_thresh);
        fifo_flags_t f;
        f.empty        = (count == 0);
        f.full         = (count == depth);
        f.almost_empty = (count <= ae_thresh);
        f.almost_full  = (count >= af_thresh);
        return f;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, read port either registered
// (loaded on an accepted pop) or asynchronous (head always visible).
module fifo_ram #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter bit REG_READ = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Storage write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            logic [DATA_W-1:0] rdata_r;

            // Registered read port, loaded only when a pop is accepted.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_r <= '0;
                end else if (re) begin
                    rdata_r <= mem_r[raddr];
                end
            end

            assign rdata = rdata_r;
        end else begin : g_async_read
            logic unused_s;
            assign unused_s = re ^ rst_n;
            assign rdata    = mem_r[raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Supports registered-read and first-word-fall-through output modes.
module sync_fifo_flags
    import fft_fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    EN,
    input  logic                    WR,
    input  logic [DATA_W-1:0]       dataIn,
    input  logic                    RD,
    output logic [DATA_W-1:0]       dataOut,
    output logic                    dataValid,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    ALMOST_EMPTY,
    output logic                    ALMOST_FULL,
    output logic [clog2(DEPTH):0]   COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1'b1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_nxt_s;
    fifo_flags_t       flags_r;
    fifo_flags_t       flags_nxt_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              ovf_r;
    logic              unf_r;
    logic              valid_r;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] ram_rdata_s;

    assign wr_acc_s = EN & WR & ~flags_r.full;
    assign rd_acc_s = EN & RD & ~flags_r.empty;

    // Next occupancy and the flag set it implies; flags are registered from this.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        flags_nxt_s = calc_flags(int'(count_nxt_s), DEPTH, AF_THRESH, AE_THRESH);
    end

    // Pointer, occupancy, flag and pulse registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            flags_r  <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            valid_r  <= 1'b0;
            hold_r   <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                hold_r   <= ram_rdata_s;
            end
            count_r <= count_nxt_s;
            flags_r <= flags_nxt_s;
            ovf_r   <= EN & WR & flags_r.full;
            unf_r   <= EN & RD & flags_r.empty;
            valid_r <= rd_acc_s;
        end
    end

    fifo_ram #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .REG_READ (FWFT == 0)
    ) u_ram (
        .clk   (Clk),
        .rst_n (Rst_n),
        .we    (wr_acc_s & Rst_n),
        .waddr (wr_ptr_r),
        .wdata (dataIn),
        .re    (rd_acc_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    // In FWFT mode the last popped word is held while empty so dataOut never shows stale RAM.
    generate
        if (FWFT != 0) begin : g_fwft
            logic unused_s;
            assign unused_s  = valid_r;
            assign dataOut   = flags_r.empty ? hold_r : ram_rdata_s;
            assign dataValid = ~flags_r.empty;
        end else begin : g_regrd
            logic unused_s;
            assign unused_s  = ^hold_r;
            assign dataOut   = ram_rdata_s;
            assign dataValid = valid_r;
        end
    endgenerate

    assign EMPTY        = flags_r.empty;
    assign FULL         = flags_r.full;
    assign ALMOST_EMPTY = flags_r.almost_empty;
    assign ALMOST_FULL  = flags_r.almost_full;
    assign COUNT        = count_r;
    assign OVERFLOW     = ovf_r;
    assign UNDERFLOW    = unf_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: registered-read instance checked via an expected-data queue,
// plus a first-word-fall-through instance checked directly.
module tb_sync_fifo_flags;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic        wr0, rd0, wr1, rd1;
    logic [31:0] din0, din1;
    logic [31:0] dout0, dout1;
    logic        valid0, empty0, full0, ae0, af0, ovf0, unf0;
    logic        valid1, empty1, full1, ae1, af1, ovf1, unf1;
    logic [4:0]  cnt0, cnt1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    sync_fifo_flags #(.FWFT(0)) dut0 (
        .Clk(clk), .Rst_n(rst_n), .EN(en), .WR(wr0), .dataIn(din0), .RD(rd0),
        .dataOut(dout0), .dataValid(valid0), .EMPTY(empty0), .FULL(full0),
        .ALMOST_EMPTY(ae0), .ALMOST_FULL(af0), .COUNT(cnt0),
        .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    sync_fifo_flags #(.FWFT(1)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .EN(en), .WR(wr1), .dataIn(din1), .RD(rd1),
        .dataOut(dout1), .dataValid(valid1), .EMPTY(empty1), .FULL(full1),
        .ALMOST_EMPTY(ae1), .ALMOST_FULL(af1), .COUNT(cnt1),
        .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset0;
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_ae", 32'(ae0), 32'd1);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_af", 32'(af0), 32'd0);
        chk("rst_dout", dout0, 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_unf", 32'(unf0), 32'd0);
        chk("rst_dout_fwft", dout1, 32'd0);
        chk("rst_valid_fwft", 32'(valid1), 32'd0);
        chk("rst_empty_fwft", 32'(empty1), 32'd1);
    endtask

    // Monitor: every dataValid beat must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid0 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: got %0h with nothing expected", dout0);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dout0 !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %0h expected %0h", dout0, mon_exp);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0;
        wr0 = 1'b0; rd0 = 1'b0; din0 = 32'd0;
        wr1 = 1'b0; rd1 = 1'b0; din1 = 32'd0;
        tick; tick;
        // Reset overrides enable and requests
        en = 1'b1; wr0 = 1'b1; din0 = 32'h55;
        tick;
        chk_reset0;
        rst_n = 1'b1; wr0 = 1'b0;

        // Five writes, then five registered reads
        for (int i = 0; i < 5; i++) begin
            wr0 = 1'b1; din0 = 32'(i);
            tick;
            chk("ae_fill", 32'(ae0), 32'((i + 1) <= 2));
        end
        wr0 = 1'b0;
        chk("cnt5", 32'(cnt0), 32'd5);
        chk("empty_cnt5", 32'(empty0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd0 = 1'b1; exp_q.push_back(32'(i));
            tick;
        end
        rd0 = 1'b0;
        chk("empty_after_drain", 32'(empty0), 32'd1);
        chk("cnt_after_drain", 32'(cnt0), 32'd0);
        tick;
        chk("valid_drop", 32'(valid0), 32'd0);

        // Fill to full plus one dropped word
        for (int i = 0; i < 17; i++) begin
            wr0 = 1'b1; din0 = 32'h100 + 32'(i);
            tick;
            if (i < 16) begin
                chk("fill_cnt", 32'(cnt0), 32'(i + 1));
                chk("fill_af", 32'(af0), 32'((i + 1) >= 14));
                chk("fill_full", 32'(full0), 32'((i + 1) == 16));
                chk("fill_ovf", 32'(ovf0), 32'd0);
            end
        end
        wr0 = 1'b0;
        chk("ovf_pulse", 32'(ovf0), 32'd1);
        chk("cnt_full", 32'(cnt0), 32'd16);
        tick;
        chk("ovf_clear", 32'(ovf0), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd0 = 1'b1; exp_q.push_back(32'h100 + 32'(i));
            tick;
        end
        rd0 = 1'b0;

        // Underflow on empty
        rd0 = 1'b1;
        tick;
        rd0 = 1'b0;
        chk("unf_pulse", 32'(unf0), 32'd1);
        chk("unf_cnt", 32'(cnt0), 32'd0);
        chk("unf_valid", 32'(valid0), 32'd0);
        tick;
        chk("unf_clear", 32'(unf0), 32'd0);
        chk("unf_dout_hold", dout0, 32'h10F);

        // Steady state at COUNT=8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            wr0 = 1'b1; din0 = 32'h200 + 32'(i);
            tick;
        end
        chk("cnt8", 32'(cnt0), 32'd8);
        for (int i = 0; i < 40; i++) begin
            wr0 = 1'b1; rd0 = 1'b1; din0 = 32'h208 + 32'(i);
            exp_q.push_back(32'h200 + 32'(i));
            tick;
            chk("cnt8_steady", 32'(cnt0), 32'd8);
        end
        wr0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd0 = 1'b1; exp_q.push_back(32'h228 + 32'(i));
            tick;
        end
        rd0 = 1'b0;

        // Enable low freezes everything
        for (int i = 0; i < 3; i++) begin
            wr0 = 1'b1; din0 = 32'h300 + 32'(i);
            tick;
        end
        en = 1'b0; wr0 = 1'b1; rd0 = 1'b1; din0 = 32'hBAD;
        repeat (3) tick;
        chk("en0_cnt", 32'(cnt0), 32'd3);
        chk("en0_valid", 32'(valid0), 32'd0);
        chk("en0_ovf", 32'(ovf0), 32'd0);
        chk("en0_unf", 32'(unf0), 32'd0);
        en = 1'b1; rd0 = 1'b0;
        for (int i = 3; i < 6; i++) begin
            wr0 = 1'b1; din0 = 32'h300 + 32'(i);
            tick;
        end
        chk("cnt6", 32'(cnt0), 32'd6);

        // Mid-operation reset with a write request
        rst_n = 1'b0; wr0 = 1'b1; din0 = 32'hDEAD;
        tick;
        chk_reset0;
        rst_n = 1'b1; wr0 = 1'b1; din0 = 32'h7;
        tick;
        wr0 = 1'b0;
        chk("post_rst_cnt", 32'(cnt0), 32'd1);
        rd0 = 1'b1; exp_q.push_back(32'h7);
        tick;
        rd0 = 1'b0;
        tick;

        // First-word-fall-through instance
        wr1 = 1'b1; din1 = 32'hA5;
        tick;
        wr1 = 1'b0;
        chk("fwft_dout", dout1, 32'hA5);
        chk("fwft_valid", 32'(valid1), 32'd1);
        chk("fwft_empty", 32'(empty1), 32'd0);
        tick;
        chk("fwft_dout_hold", dout1, 32'hA5);
        rd1 = 1'b1;
        tick;
        rd1 = 1'b0;
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_pop_valid", 32'(valid1), 32'd0);
        wr1 = 1'b1; din1 = 32'hB1;
        tick;
        din1 = 32'hB2;
        tick;
        wr1 = 1'b0;
        chk("fwft_head1", dout1, 32'hB1);
        chk("fwft_cnt2", 32'(cnt1), 32'd2);
        rd1 = 1'b1;
        tick;
        rd1 = 1'b0;
        chk("fwft_head2", dout1, 32'hB2);
        chk("fwft_valid2", 32'(valid1), 32'd1);
        rd1 = 1'b1;
        tick;
        chk("fwft_empty2", 32'(empty1), 32'd1);
        tick;
        rd1 = 1'b0;
        chk("fwft_unf", 32'(unf1), 32'd1);

        tick; tick;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >= 4.
REQ-003 Parameter AF_THRESH, default DEPTH-2, ALMOST_FULL asserts at COUNT >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2, ALMOST_EMPTY asserts at COUNT <= AE_THRESH.
REQ-005 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 Clk  input  1  single clock; all state updates on the rising edge.
REQ-007 Rst_n  input  1  synchronous, active-low reset.
REQ-008 EN  input  1  global enable; 0 freezes all state and outputs.
REQ-009 WR  input  1  write request.
REQ-010 dataIn  input  DATA_W  write data.
REQ-011 RD  input  1  read request (read acknowledge in FWFT mode).
REQ-012 dataOut  output  DATA_W  read data.
REQ-013 dataValid  output  1  dataOut holds a valid popped word (mode-dependent, see Function).
REQ-014 EMPTY / FULL  output  1 each  COUNT==0 / COUNT==DEPTH.
REQ-015 ALMOST_EMPTY / ALMOST_FULL  output  1 each  threshold flags.
REQ-016 COUNT  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 OVERFLOW / UNDERFLOW  output  1 each  one-cycle pulse on rejected write / rejected read.

Function
REQ-018 Write accepted iff EN & WR & !FULL; word stored at write pointer, pointer increments modulo DEPTH.
REQ-019 Read accepted iff EN & RD & !EMPTY; read pointer increments modulo DEPTH.
REQ-020 Simultaneous accepted read and write: both pointers advance, COUNT unchanged; valid at any occupancy except FULL (write rejected) or EMPTY (read rejected).
REQ-021 Write while FULL: word dropped, no state change, OVERFLOW = 1 for exactly the next cycle.
REQ-022 Read while EMPTY: no pointer change, dataOut holds, UNDERFLOW = 1 for exactly the next cycle.
REQ-023 COUNT, EMPTY, FULL, ALMOST_* update in the cycle after the accepted operation; all flags derive from registered COUNT only.
REQ-024 FWFT=0: dataOut registered, updated one cycle after an accepted read; dataValid = 1 for that one cycle, else 0; dataOut holds last value otherwise.
REQ-025 FWFT=1: dataOut presents head entry whenever !EMPTY; dataValid = !EMPTY; RD pops head, next entry visible the following cycle; first write into empty FIFO visible one cycle after the write.
REQ-026 EN=0: requests ignored, no OVERFLOW/UNDERFLOW pulse, all outputs hold (dataValid forced 0 in FWFT=0 mode).
REQ-027 Pointers ADDR_W = log2(DEPTH) bits, wrap without gap; ordering strictly first-in first-out across wrap.

Reset
REQ-028 Rst_n=0 at a rising edge overrides EN and all requests.
REQ-029 Reset values: pointers 0, COUNT 0, EMPTY 1, FULL 0, ALMOST_EMPTY 1, ALMOST_FULL 0, dataOut 0, dataValid 0, OVERFLOW 0, UNDERFLOW 0.
REQ-030 Storage array not cleared; reset mid-operation discards all contents, first post-reset read returns first post-reset write.

Structure
REQ-031 Shared package fft_fifo_pkg holds default DATA_W/DEPTH constants and the log2 helper function used for ADDR_W.
REQ-032 Storage in one sub-module fifo_ram: simple dual-port, synchronous write, async read (FWFT) / registered read (FWFT=0) selected by parameter.

Verification
REQ-033 Reset, EN=1, write 0x0..0x4 on 5 consecutive cycles -> COUNT=5, EMPTY=0, ALMOST_EMPTY=0; then RD 5 cycles (FWFT=0) -> dataOut 0x0..0x4 each one cycle after request, dataValid high 5 cycles, EMPTY=1 at end.
REQ-034 DEPTH=16: write 17 words -> FULL=1 after 16th, 17th dropped, OVERFLOW single pulse, COUNT=16; ALMOST_FULL first high at COUNT=14.
REQ-035 Empty FIFO, RD=1 -> UNDERFLOW single pulse, dataOut unchanged, COUNT=0.
REQ-036 COUNT=8, simultaneous WR+RD for 40 cycles with incrementing data -> COUNT stays 8, output sequence contiguous across pointer wrap.
REQ-037 FWFT=1: write 0xA5 into empty -> dataOut=0xA5, dataValid=1 next cycle without RD; RD pops, EMPTY=1 following cycle.
REQ-038 COUNT=6, Rst_n=0 one cycle with WR=1 -> all REQ-029 values, write ignored; next write 0x7 then read returns 0x7.
